// File: rtl/c906_mem_bist_pkg.sv
// Shared types and pattern generator for the C906 SRAM march BIST.
// Both march pattern sets are derived from a single seed XORed with the address.
package c906_mem_bist_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WA    = 3'd1,
        RA    = 3'd2,
        WB    = 3'd3,
        RB    = 3'd4,
        DRAIN = 3'd5,
        DONE  = 3'd6
    } bist_state_e;

    localparam int unsigned PAT_W = 64;

    // Full-width pattern; callers truncate to their data width.
    function automatic logic [PAT_W-1:0] pattern(input logic [PAT_W-1:0] addr,
                                                 input logic             inv,
                                                 input logic [PAT_W-1:0] seed);
        logic [PAT_W-1:0] p;
        p = seed ^ addr;
        return inv ? ~p : p;
    endfunction

endpackage

// File: rtl/c906_mem_bist_if.sv
// Single-port SRAM bus between the BIST engine (master) and the array (slave).
interface c906_mem_bist_if #(
    parameter int unsigned ADDR_WIDTH = 9,
    parameter int unsigned DATA_WIDTH = 64
);
    logic                  mem_cen_b;
    logic                  mem_wen_b;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_din;
    logic [DATA_WIDTH-1:0] mem_dout;

    modport master (
        output mem_cen_b, mem_wen_b, mem_addr, mem_din,
        input  mem_dout
    );

    modport slave (
        input  mem_cen_b, mem_wen_b, mem_addr, mem_din,
        output mem_dout
    );
endinterface

// File: rtl/c906_mem_bist_chk.sv
// Read-data checker: one-stage expected-data pipe aligned to SRAM read latency,
// comparator and sticky fail flag.
module c906_mem_bist_chk #(
    parameter int unsigned DATA_WIDTH = 64
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  rd_vld_i,
    input  logic [DATA_WIDTH-1:0] rd_exp_i,
    input  logic [DATA_WIDTH-1:0] mem_dout_i,
    output logic                  fail_o
);
    logic                  chk_vld_q;
    logic [DATA_WIDTH-1:0] exp_q;
    logic                  fail_q;
    logic                  fail_d;
    logic                  mismatch;

    // mem_dout is only looked at while a check is pending, so X elsewhere is harmless.
    assign mismatch = chk_vld_q && (mem_dout_i != exp_q);
    assign fail_d   = fail_q | mismatch;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            chk_vld_q <= 1'b0;
            exp_q     <= '0;
            fail_q    <= 1'b0;
        end else begin
            chk_vld_q <= rd_vld_i;
            exp_q     <= rd_exp_i;
            fail_q    <= fail_d;
        end
    end

    assign fail_o = fail_q;

endmodule

// File: rtl/c906_mem_bist.sv
// Self-starting 4-phase march BIST for one C906 single-port SRAM: FSM, address
// counter and registered SRAM drive; read checking lives in c906_mem_bist_chk.
module c906_mem_bist
    import c906_mem_bist_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 9,
    parameter int unsigned DATA_WIDTH = 64,
    parameter logic [63:0] SEED       = 64'h5555_5555_5555_5555
) (
    input  logic               forever_cpuclk,
    input  logic               cpurst_b,
    c906_mem_bist_if.master    mem,
    output logic               bist_done,
    output logic               mem_test_pass,
    output logic               mem_test_fail
);
    localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = '1;

    bist_state_e           state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  cen_q, cen_d;
    logic                  wen_q, wen_d;
    logic [DATA_WIDTH-1:0] din_q, din_d;
    logic                  done_q, done_d;
    logic                  rd_vld;
    logic [DATA_WIDTH-1:0] rd_exp;
    logic                  chk_fail;

    function automatic logic [DATA_WIDTH-1:0] pat_at(input logic [ADDR_WIDTH-1:0] a,
                                                      input logic                  inv);
        logic [PAT_W-1:0] full;
        full = pattern(PAT_W'(a), inv, SEED);
        return full[DATA_WIDTH-1:0];
    endfunction

    // Next state and next registered port values; din is zero unless writing.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cen_d   = cen_q;
        wen_d   = wen_q;
        din_d   = '0;
        done_d  = done_q;
        case (state_q)
            IDLE: begin
                state_d = WA;
                addr_d  = '0;
                cen_d   = 1'b0;
                wen_d   = 1'b0;
                din_d   = pat_at('0, 1'b0);
            end
            WA: begin
                if (addr_q == ADDR_MAX) begin
                    state_d = RA;
                    addr_d  = '0;
                    wen_d   = 1'b1;
                end else begin
                    addr_d = addr_q + 1'b1;
                    din_d  = pat_at(addr_q + 1'b1, 1'b0);
                end
            end
            RA: begin
                if (addr_q == ADDR_MAX) begin
                    state_d = WB;
                    addr_d  = ADDR_MAX;
                    wen_d   = 1'b0;
                    din_d   = pat_at(ADDR_MAX, 1'b1);
                end else begin
                    addr_d = addr_q + 1'b1;
                end
            end
            WB: begin
                if (addr_q == '0) begin
                    state_d = RB;
                    addr_d  = ADDR_MAX;
                    wen_d   = 1'b1;
                end else begin
                    addr_d = addr_q - 1'b1;
                    din_d  = pat_at(addr_q - 1'b1, 1'b1);
                end
            end
            RB: begin
                if (addr_q == '0) begin
                    state_d = DRAIN;
                    cen_d   = 1'b1;
                end else begin
                    addr_d = addr_q - 1'b1;
                end
            end
            DRAIN: begin
                state_d = DONE;
                done_d  = 1'b1;
            end
            DONE: begin
                state_d = DONE;
            end
            default: begin
                state_d = IDLE;
                cen_d   = 1'b1;
                wen_d   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            state_q <= IDLE;
            addr_q  <= '0;
            cen_q   <= 1'b1;
            wen_q   <= 1'b1;
            din_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cen_q   <= cen_d;
            wen_q   <= wen_d;
            din_q   <= din_d;
            done_q  <= done_d;
        end
    end

    // A read is issued in every cycle the registered port shows cen=0, wen=1.
    assign rd_vld = ~cen_q & wen_q;
    assign rd_exp = pat_at(addr_q, state_q == RB);

    c906_mem_bist_chk #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_chk (
        .clk_i      (forever_cpuclk),
        .rst_n_i    (cpurst_b),
        .rd_vld_i   (rd_vld),
        .rd_exp_i   (rd_exp),
        .mem_dout_i (mem.mem_dout),
        .fail_o     (chk_fail)
    );

    assign mem.mem_cen_b = cen_q;
    assign mem.mem_wen_b = wen_q;
    assign mem.mem_addr  = addr_q;
    assign mem.mem_din   = din_q;
    assign bist_done     = done_q;
    assign mem_test_fail = chk_fail;
    // Pass cannot assert before done, and a late DRAIN mismatch lands together with done.
    assign mem_test_pass = done_q & ~chk_fail;

endmodule

// File: tb/tb_c906_mem_bist.sv
// Directed bench for c906_mem_bist (ADDR_WIDTH=4, DATA_WIDTH=16) with a
// behavioural 1-cycle-latency SRAM that can inject a few fault types.
module tb_c906_mem_bist;

    logic clk;
    logic rst_n;
    logic bist_done, mem_test_pass, mem_test_fail;

    int n_cmp;
    int n_err;
    int cyc;
    int fault;
    int rd_cnt;

    logic [15:0] mem_arr [16];
    logic [3:0]  sa;
    logic [15:0] sd;

    c906_mem_bist_if #(.ADDR_WIDTH(4), .DATA_WIDTH(16)) bus ();

    c906_mem_bist #(
        .ADDR_WIDTH(4),
        .DATA_WIDTH(16),
        .SEED      (64'h5555_5555_5555_5555)
    ) dut (
        .forever_cpuclk (clk),
        .cpurst_b       (rst_n),
        .mem            (bus),
        .bist_done      (bist_done),
        .mem_test_pass  (mem_test_pass),
        .mem_test_fail  (mem_test_fail)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Fault modes: 1 stuck-at-0 bit 3 @ addr 5, 2 addr bit 2 ignored, 3 corrupt 32nd read.
    always @(posedge clk) begin
        if (!rst_n) begin
            rd_cnt = 0;
        end else if (!bus.mem_cen_b) begin
            sa = bus.mem_addr;
            if (fault == 2) sa[2] = 1'b0;
            if (!bus.mem_wen_b) begin
                sd = bus.mem_din;
                if (fault == 1 && sa == 4'd5) sd[3] = 1'b0;
                mem_arr[sa] <= sd;
            end else begin
                rd_cnt = rd_cnt + 1;
                sd = mem_arr[sa];
                if (fault == 3 && rd_cnt == 32) sd = sd ^ 16'h0001;
                bus.mem_dout <= sd;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int c);
        while (cyc < c) step();
    endtask

    // Cycle 0 is the stretch between reset release and the first posedge.
    task automatic start_test(input int f);
        fault = f;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        cyc = 0;
    endtask

    typedef struct {
        int          c;
        logic        cen;
        logic        wen;
        logic [3:0]  addr;
        logic [15:0] din;
        logic        done;
        logic        pass;
        logic        fail;
    } vec_t;

    localparam int NV = 12;
    vec_t tbl [NV];

    initial begin
        int  k;
        logic early_pass;
        logic [15:0] exp_din;

        n_cmp = 0;
        n_err = 0;
        cyc   = 0;
        fault = 0;
        rst_n = 1'b0;
        bus.mem_dout = 'x;

        // Hand-computed: PA(a)=5555^a, PB(a)=~PA(a); 66 = 4*16+2 cycles to done.
        tbl[0]  = '{ 0, 1'b1, 1'b1, 4'h0, 16'h0000, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{ 1, 1'b0, 1'b0, 4'h0, 16'h5555, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{ 6, 1'b0, 1'b0, 4'h5, 16'h5550, 1'b0, 1'b0, 1'b0};
        tbl[3]  = '{16, 1'b0, 1'b0, 4'hF, 16'h555A, 1'b0, 1'b0, 1'b0};
        tbl[4]  = '{17, 1'b0, 1'b1, 4'h0, 16'h0000, 1'b0, 1'b0, 1'b0};
        tbl[5]  = '{32, 1'b0, 1'b1, 4'hF, 16'h0000, 1'b0, 1'b0, 1'b0};
        tbl[6]  = '{33, 1'b0, 1'b0, 4'hF, 16'hAAA5, 1'b0, 1'b0, 1'b0};
        tbl[7]  = '{48, 1'b0, 1'b0, 4'h0, 16'hAAAA, 1'b0, 1'b0, 1'b0};
        tbl[8]  = '{49, 1'b0, 1'b1, 4'hF, 16'h0000, 1'b0, 1'b0, 1'b0};
        tbl[9]  = '{64, 1'b0, 1'b1, 4'h0, 16'h0000, 1'b0, 1'b0, 1'b0};
        tbl[10] = '{65, 1'b1, 1'b1, 4'h0, 16'h0000, 1'b0, 1'b0, 1'b0};
        tbl[11] = '{66, 1'b1, 1'b1, 4'h0, 16'h0000, 1'b1, 1'b1, 1'b0};

        // Good SRAM: table-driven port protocol and completion timing.
        start_test(0);
        k = 0;
        early_pass = 1'b0;
        for (int c = 0; c <= 66; c++) begin
            if (c > 0) step();
            if (mem_test_pass && !bist_done) early_pass = 1'b1;
            if (k < NV && tbl[k].c == c) begin
                check("cen",  32'(bus.mem_cen_b), 32'(tbl[k].cen));
                check("wen",  32'(bus.mem_wen_b), 32'(tbl[k].wen));
                check("addr", 32'(bus.mem_addr),  32'(tbl[k].addr));
                check("din",  32'(bus.mem_din),   32'(tbl[k].din));
                check("done", 32'(bist_done),     32'(tbl[k].done));
                check("pass", 32'(mem_test_pass), 32'(tbl[k].pass));
                check("fail", 32'(mem_test_fail), 32'(tbl[k].fail));
                k++;
            end
            if (c >= 1 && c <= 16) begin
                exp_din = 16'h5555 ^ 16'(c - 1);
                check("wa_din", 32'(bus.mem_din), 32'(exp_din));
            end
            if (c >= 49 && c <= 64)
                check("rb_addr", 32'(bus.mem_addr), 32'(64 - c));
        end
        check("tbl_applied", 32'(k), 32'(NV));
        check("pass_before_done", 32'(early_pass), 32'd0);
        run_to(72);
        check("done_cen_idle", 32'(bus.mem_cen_b), 32'd1);
        check("pass_sticky",   32'(mem_test_pass), 32'd1);

        // Stuck-at-0 bit 3 @ 5: PA(5)=5550 already has bit 3 clear, so only PB(5)=AAAF exposes it.
        start_test(1);
        run_to(34);
        check("sa0_fail_ra", 32'(mem_test_fail), 32'd0);
        run_to(60);
        check("sa0_fail_pre", 32'(mem_test_fail), 32'd0);
        run_to(61);
        check("sa0_fail_rb", 32'(mem_test_fail), 32'd1);
        run_to(66);
        check("sa0_done", 32'(bist_done),     32'd1);
        check("sa0_pass", 32'(mem_test_pass), 32'd0);

        // Address aliasing: read of addr 0 issued in cycle 17 returns PA(4).
        start_test(2);
        run_to(18);
        check("alias_fail_pre", 32'(mem_test_fail), 32'd0);
        run_to(19);
        check("alias_fail_ra", 32'(mem_test_fail), 32'd1);
        run_to(66);
        check("alias_pass", 32'(mem_test_pass), 32'd0);

        // Corrupt only the final RB read; compared in DRAIN, visible with done.
        start_test(3);
        run_to(65);
        check("last_fail_pre", 32'(mem_test_fail), 32'd0);
        check("last_done_pre", 32'(bist_done),     32'd0);
        run_to(66);
        check("last_fail",  32'(mem_test_fail), 32'd1);
        check("last_done",  32'(bist_done),     32'd1);
        check("last_pass",  32'(mem_test_pass), 32'd0);

        // Reset mid-WB aborts asynchronously, then a clean rerun.
        start_test(0);
        run_to(40);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_cen",  32'(bus.mem_cen_b), 32'd1);
        check("rst_wen",  32'(bus.mem_wen_b), 32'd1);
        check("rst_addr", 32'(bus.mem_addr),  32'd0);
        check("rst_din",  32'(bus.mem_din),   32'd0);
        check("rst_done", 32'(bist_done),     32'd0);
        check("rst_flags", 32'({mem_test_pass, mem_test_fail}), 32'd0);
        start_test(0);
        run_to(65);
        check("rerun_done_pre", 32'(bist_done), 32'd0);
        run_to(66);
        check("rerun_done", 32'(bist_done),     32'd1);
        check("rerun_pass", 32'(mem_test_pass), 32'd1);
        check("rerun_fail", 32'(mem_test_fail), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
